link_pulse_gen: RTL and testbench

- Parametrised 10BASE-T link pulse generator. Successor to the fixed single-NLP timer.
- Supports two modes:
  - NLP: one pulse per period.
  - FLP: a 33-slot fast link pulse burst per period, carrying a 16-bit auto-negotiation code word.
- Sits between the MAC/auto-negotiation control and the TD line driver.
- Suppresses pulses while data is transmitting, and reports word consumption and burst completion to the auto-negotiation FSM.

---
 rtl/link_pulse_if.sv | 22 ++
 rtl/link_pulse_gen.sv | 132 +++++++++++++
 tb/tb_link_pulse_gen.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/link_pulse_if.sv
// Control/status bundle between auto-negotiation logic and the link pulse generator.
interface link_pulse_if #(
  parameter int unsigned CW_W = 16
);
  logic            en;
  logic            mode;
  logic            tx_busy;
  logic [CW_W-1:0] link_cw;
  logic            tx_p;
  logic            cw_ack;
  logic            burst_done;

  modport master (
    output en, mode, tx_busy, link_cw,
    input  tx_p, cw_ack, burst_done
  );

  modport slave (
    input  en, mode, tx_busy, link_cw,
    output tx_p, cw_ack, burst_done
  );
endinterface

// File: rtl/link_pulse_gen.sv
// 10BASE-T link pulse generator: one NLP or a 33-slot FLP burst every PERIOD cycles.
// Pulses are suppressed and the period timer restarts while data is transmitting.
module link_pulse_gen #(
  parameter int unsigned PERIOD  = 320000,
  parameter int unsigned SLOT    = 1250,
  parameter int unsigned PULSE_W = 2,
  parameter int unsigned CW_W    = 16
) (
  input  logic       clk,
  input  logic       resetn,
  link_pulse_if.slave lp
);

  localparam int unsigned N_SLOT = 2 * CW_W + 1;
  localparam int unsigned LAST_K = N_SLOT - 1;
  localparam int unsigned PC_W   = $clog2(PERIOD);
  localparam int unsigned SO_W   = $clog2(SLOT);
  localparam int unsigned K_W    = $clog2(N_SLOT);

  if (!(PULSE_W >= 1 && PULSE_W < SLOT && N_SLOT * SLOT < PERIOD)) begin : g_param_err
    $error("link_pulse_gen: illegal PERIOD/SLOT/PULSE_W/CW_W combination");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [SO_W-1:0] so_q, so_d;
  logic [K_W-1:0]  k_q, k_d;
  logic            mode_q, mode_d;
  logic [CW_W-1:0] cw_q, cw_d;
  logic            tx_p_q, tx_p_d;
  logic            cw_ack_q, cw_ack_d;
  logic            burst_done_q, burst_done_d;

  logic [K_W-1:0]  last_k;
  logic            data_bit;
  logic            populated;

  // so_q/k_q track the slot position of the current cycle; outputs reflect the next one.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    so_d         = so_q;
    k_d          = k_q;
    mode_d       = mode_q;
    cw_d         = cw_q;
    tx_p_d       = 1'b0;
    cw_ack_d     = 1'b0;
    burst_done_d = 1'b0;
    last_k       = '0;
    data_bit     = 1'b0;
    populated    = 1'b0;

    if (!lp.en || lp.tx_busy) begin
      pc_d    = '0;
      so_d    = '0;
      k_d     = '0;
      state_d = IDLE;
    end else if (pc_q == PC_W'(PERIOD - 1)) begin
      // Wrap starts a group; slot 0 is always populated.
      pc_d     = '0;
      so_d     = '0;
      k_d      = '0;
      state_d  = PULSE;
      mode_d   = lp.mode;
      cw_d     = lp.link_cw;
      cw_ack_d = 1'b1;
      tx_p_d   = 1'b1;
    end else begin
      pc_d = pc_q + PC_W'(1);
      if (state_q == DONE) begin
        so_d    = '0;
        k_d     = '0;
        state_d = IDLE;
      end else if (state_q != IDLE) begin
        if (so_q == SO_W'(SLOT - 1)) begin
          so_d = '0;
          k_d  = k_q + K_W'(1);
        end else begin
          so_d = so_q + SO_W'(1);
        end
        last_k    = mode_q ? K_W'(LAST_K) : '0;
        data_bit  = |(cw_q & (CW_W'(1) << k_d[K_W-1:1]));
        populated = (k_d == '0) || (mode_q && (!k_d[0] || data_bit));
        if (k_d == last_k && so_d == SO_W'(PULSE_W)) begin
          state_d      = DONE;
          burst_done_d = 1'b1;
        end else if (so_d < SO_W'(PULSE_W)) begin
          state_d = PULSE;
          tx_p_d  = populated;
        end else begin
          state_d = GAP;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      so_q         <= '0;
      k_q          <= '0;
      mode_q       <= 1'b0;
      cw_q         <= '0;
      tx_p_q       <= 1'b0;
      cw_ack_q     <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      so_q         <= so_d;
      k_q          <= k_d;
      mode_q       <= mode_d;
      cw_q         <= cw_d;
      tx_p_q       <= tx_p_d;
      cw_ack_q     <= cw_ack_d;
      burst_done_q <= burst_done_d;
    end
  end

  assign lp.tx_p       = tx_p_q;
  assign lp.cw_ack     = cw_ack_q;
  assign lp.burst_done = burst_done_q;

endmodule

// File: tb/tb_link_pulse_gen.sv
// Bench for link_pulse_gen: directed scenarios plus random traffic against a
// timeline model (group start time + offset arithmetic).
module tb_link_pulse_gen;

  localparam int unsigned PERIOD  = 2000;
  localparam int unsigned SLOT    = 50;
  localparam int unsigned PULSE_W = 2;
  localparam int unsigned CW_W    = 16;

  logic clk;
  logic resetn;

  link_pulse_if #(.CW_W(CW_W)) lp ();

  link_pulse_gen #(
    .PERIOD (PERIOD),
    .SLOT   (SLOT),
    .PULSE_W(PULSE_W),
    .CW_W   (CW_W)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .lp    (lp.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;
  int base     = 0;

  // Timeline model: cycle index, qualifying-cycle run length, last group start.
  int              cyc    = 0;
  int              run    = 0;
  bit              active = 1'b0;
  int              gs     = 0;
  bit              g_mode = 1'b0;
  logic [CW_W-1:0] g_cw   = '0;

  task automatic check(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (cycle %0d, rel %0d)", name, got, exp, cyc, cyc - base);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!(resetn && lp.en && !lp.tx_busy)) begin
      run    <= 0;
      active <= 1'b0;
    end else begin
      run <= run + 1;
      if ((run + 1) % PERIOD == 0) begin
        active <= 1'b1;
        gs     <= cyc + 1;
        g_mode <= lp.mode;
        g_cw   <= lp.link_cw;
      end
    end
  end

  // Per-cycle comparison of all outputs against the timeline model.
  always @(negedge clk) begin
    automatic bit etx   = 1'b0;
    automatic bit eack  = 1'b0;
    automatic bit edone = 1'b0;
    automatic int d, k, so, last;
    if (chk_on) begin
      if (active) begin
        d    = cyc - gs;
        k    = d / SLOT;
        so   = d % SLOT;
        last = g_mode ? 2 * CW_W : 0;
        eack = (d == 0);
        if (d == last * SLOT + PULSE_W)
          edone = 1'b1;
        else if (k <= last && so < PULSE_W)
          etx = (k % 2 == 0) || g_cw[(k - 1) / 2];
      end
      check("tx_p", lp.tx_p, etx);
      check("cw_ack", lp.cw_ack, eack);
      check("burst_done", lp.burst_done, edone);
    end
  end

  task automatic at(input int rel);
    while (cyc < base + rel) @(negedge clk);
  endtask

  task automatic start(input bit mode, input logic [CW_W-1:0] cw);
    resetn     = 1'b0;
    lp.en      = 1'b0;
    lp.tx_busy = 1'b0;
    repeat (3) @(negedge clk);
    lp.mode    = mode;
    lp.link_cw = cw;
    lp.en      = 1'b1;
    resetn     = 1'b1;
    base       = cyc;
  endtask

  initial begin
    resetn     = 1'b0;
    lp.en      = 1'b0;
    lp.mode    = 1'b0;
    lp.tx_busy = 1'b0;
    lp.link_cw = '0;
    @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    check("reset tx_p", lp.tx_p, 1'b0);
    check("reset cw_ack", lp.cw_ack, 1'b0);
    check("reset burst_done", lp.burst_done, 1'b0);

    // NLP
    start(1'b0, 16'($urandom));
    at(1999); check("nlp tx@1999", lp.tx_p, 1'b0);
    at(2000); check("nlp tx@2000", lp.tx_p, 1'b1); check("nlp ack@2000", lp.cw_ack, 1'b1);
    at(2001); check("nlp tx@2001", lp.tx_p, 1'b1);
    at(2002); check("nlp tx@2002", lp.tx_p, 1'b0); check("nlp done@2002", lp.burst_done, 1'b1);
    at(4000); check("nlp tx@4000", lp.tx_p, 1'b1); check("nlp ack@4000", lp.cw_ack, 1'b1);
    at(4002); check("nlp done@4002", lp.burst_done, 1'b1);
    at(6001); check("nlp tx@6001", lp.tx_p, 1'b1);
    at(6005);

    // FLP, all-zero code word
    start(1'b1, 16'h0000);
    at(2050); check("flp0 tx@2050", lp.tx_p, 1'b0);
    at(2100); check("flp0 tx@2100", lp.tx_p, 1'b1);
    at(3600); check("flp0 tx@3600", lp.tx_p, 1'b1);
    at(3602); check("flp0 done@3602", lp.burst_done, 1'b1);
    at(4000); check("flp0 tx@4000", lp.tx_p, 1'b1);
    at(4200);

    // FLP, 0xFFFF then 0x0001 for the second burst
    start(1'b1, 16'hFFFF);
    at(2050); check("flpF tx@2050", lp.tx_p, 1'b1);
    at(2100); lp.link_cw = 16'h0001;
    at(3550); check("flpF tx@3550", lp.tx_p, 1'b1);
    at(4050); check("flp1 tx@4050", lp.tx_p, 1'b1);
    at(4150); check("flp1 tx@4150", lp.tx_p, 1'b0);
    at(5700);

    // Mid-burst code word change
    start(1'b1, 16'hFFFF);
    at(2300); lp.link_cw = 16'h0000;
    at(2350); check("midcw tx@2350", lp.tx_p, 1'b1);
    at(4050); check("midcw tx@4050", lp.tx_p, 1'b0);
    at(4200);

    // tx_busy during a burst
    start(1'b1, 16'($urandom));
    at(2500); check("busy tx@2500", lp.tx_p, 1'b1); lp.tx_busy = 1'b1;
    at(2501); check("busy tx@2501", lp.tx_p, 1'b0);
    at(3000); lp.tx_busy = 1'b0;
    at(3602); check("busy done@3602", lp.burst_done, 1'b0);
    at(4000); check("busy tx@4000", lp.tx_p, 1'b0);
    at(5000); check("busy tx@5000", lp.tx_p, 1'b1); check("busy ack@5000", lp.cw_ack, 1'b1);
    at(5200);

    // en dropped mid-burst, re-enabled at 2200
    start(1'b1, 16'hFFFF);
    at(2010); lp.en = 1'b0;
    at(2050); check("en tx@2050", lp.tx_p, 1'b0);
    at(2200); lp.en = 1'b1;
    at(4000); check("en tx@4000", lp.tx_p, 1'b0);
    at(4200); check("en tx@4200", lp.tx_p, 1'b1);
    at(4300);

    // resetn low mid-burst, released at 2300
    start(1'b1, 16'hFFFF);
    at(2010); resetn = 1'b0;
    at(2050); check("rst tx@2050", lp.tx_p, 1'b0);
    at(2300); resetn = 1'b1;
    at(4300); check("rst tx@4300", lp.tx_p, 1'b1);
    at(4400);

    // Random traffic
    start(1'($urandom), 16'($urandom));
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      lp.mode    = 1'($urandom);
      lp.link_cw = 16'($urandom);
      lp.tx_busy = ($urandom_range(0, 4999) == 0);
      lp.en      = ($urandom_range(0, 7999) != 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
